lector_contadores: RTL and testbench

- Requester side of the FIFO pop-counter readout interface: issues `req`/`idx` read transactions to the counter block.
- Captures each returned `data_out`/`valid` reply and scans all counters sequentially on a single `start` command.
- Presents a stable snapshot of every counter plus their sum to the test/status logic.
- Detects non-responding reads with a per-read timeout.

---
 rtl/lector_contadores.sv | 104 ++++++++++
 tb/tb_lector_contadores.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/lector_contadores.sv
// lector_contadores: sequential readout of NUM_CNT pop counters over a req/idx/valid link,
// producing a stable snapshot, their sum, and a per-read timeout error.
module lector_contadores #(
  parameter int DATA_W  = 5,
  parameter int NUM_CNT = 5,
  parameter int TIMEOUT = 4
) (
  input  logic                      clk,
  input  logic                      reset_L,
  input  logic                      start,
  input  logic                      idle,
  input  logic                      valid,
  input  logic [DATA_W-1:0]         data_in,
  output logic                      req,
  output logic [2:0]                idx,
  output logic                      busy,
  output logic                      done,
  output logic                      error,
  output logic [2:0]                err_idx,
  output logic [NUM_CNT*DATA_W-1:0] snapshot,
  output logic [DATA_W+2:0]         total
);
  localparam int TW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  state_t                    state_q, state_d;
  logic [2:0]                idx_q, idx_d, err_idx_q, err_idx_d;
  logic [TW-1:0]             timer_q, timer_d;
  logic [NUM_CNT*DATA_W-1:0] snap_q, snap_d;
  logic [DATA_W+2:0]         total_q, total_d;
  logic                      error_q, error_d, busy_q, busy_d;
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      err_idx_q <= '0;
      timer_q   <= '0;
      snap_q    <= '0;
      total_q   <= '0;
      error_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      err_idx_q <= err_idx_d;
      timer_q   <= timer_d;
      snap_q    <= snap_d;
      total_q   <= total_d;
      error_q   <= error_d;
      busy_q    <= busy_d;
    end
  end
  // Every request is followed by at least one WAIT cycle, so a reply always pairs with idx_q.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    err_idx_d = err_idx_q;
    timer_d   = timer_q;
    snap_d    = snap_q;
    total_d   = total_q;
    error_d   = error_q;
    busy_d    = busy_q;
    case (state_q)
      IDLE: if (start && idle) begin
        idx_d     = '0;
        total_d   = '0;
        error_d   = 1'b0;
        err_idx_d = '0;
        busy_d    = 1'b1;
        state_d   = ISSUE;
      end
      ISSUE: begin
        timer_d = '0;
        state_d = WAIT;
      end
      WAIT: if (valid) begin
        snap_d[idx_q*DATA_W +: DATA_W] = data_in;
        total_d = total_q + (DATA_W+3)'(data_in);
        if (idx_q == 3'(NUM_CNT - 1)) begin
          busy_d  = 1'b0;
          state_d = DONE;
        end else begin
          idx_d   = idx_q + 3'd1;
          state_d = ISSUE;
        end
      end else if (timer_q == TW'(TIMEOUT - 1)) begin
        error_d   = 1'b1;
        err_idx_d = idx_q;
        busy_d    = 1'b0;
        state_d   = IDLE;
      end else begin
        timer_d = timer_q + TW'(1);
      end
      default: state_d = IDLE;
    endcase
  end
  assign req      = state_q == ISSUE;
  assign done     = state_q == DONE;
  assign idx      = idx_q;
  assign busy     = busy_q;
  assign error    = error_q;
  assign err_idx  = err_idx_q;
  assign snapshot = snap_q;
  assign total    = total_q;
endmodule

// File: tb/tb_lector_contadores.sv
// tb_lector_contadores: directed bench for lector_contadores with a behavioural counter
// block that answers each request one cycle after it is sampled.
module tb_lector_contadores;
  localparam int DW = 5, N = 5, TO = 4;
  logic clk = 1'b0, reset_L = 1'b0, start = 1'b0, idle = 1'b1, valid = 1'b0, resp_en = 1'b1;
  logic [DW-1:0] data_in = '0;
  logic req, busy, done, error;
  logic [2:0] idx, err_idx;
  logic [N*DW-1:0] snapshot;
  logic [DW+2:0] total;
  logic [DW-1:0] cnt [N];
  int n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  lector_contadores #(.DATA_W(DW), .NUM_CNT(N), .TIMEOUT(TO)) dut (
    .clk(clk), .reset_L(reset_L), .start(start), .idle(idle), .valid(valid),
    .data_in(data_in), .req(req), .idx(idx), .busy(busy), .done(done),
    .error(error), .err_idx(err_idx), .snapshot(snapshot), .total(total)
  );

  // Counter block: samples req/idx mid-cycle, replies during the following cycle.
  initial begin
    logic p;
    logic [2:0] pi;
    forever begin
      @(negedge clk);
      p = req && resp_en;
      pi = idx;
      @(posedge clk);
      #1;
      valid = p;
      data_in = p ? cnt[pi] : '0;
    end
  end

  task automatic set_cnt(input logic [DW-1:0] a, b, c, d, e);
    cnt[0] = a; cnt[1] = b; cnt[2] = c; cnt[3] = d; cnt[4] = e;
  endtask

  task automatic start_pulse();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    n_chk++;
    if ({req, idx, busy, done, error, err_idx, snapshot, total} !== '0) begin
      n_fail++;
      $display("FAIL %s: outputs req=%b idx=%0d busy=%b done=%b error=%b err_idx=%0d snap=%h total=%0d, expected all 0",
               tag, req, idx, busy, done, error, err_idx, snapshot, total);
    end
  endtask

  task automatic run_scan(input logic spur, input logic restart, input logic [7:0] exp_total, input string tag);
    int dones;
    logic exp_req;
    logic [2:0] exp_idx;
    logic [N*DW-1:0] exp_snap;
    dones = 0;
    for (int i = 0; i < N; i++) exp_snap[i*DW +: DW] = cnt[i];
    start_pulse();
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      exp_req = (k % 2 == 1) && (k <= 9);
      exp_idx = 3'(k <= 10 ? (k - 1) / 2 : 4);
      n_chk++;
      if ({req, idx, busy, done, error} !== {exp_req, exp_idx, k <= 10, k == 11, 1'b0}) begin
        n_fail++;
        $display("FAIL %s cycle %0d: req=%b idx=%0d busy=%b done=%b error=%b, expected req=%b idx=%0d busy=%b done=%b error=0",
                 tag, k, req, idx, busy, done, error, exp_req, exp_idx, k <= 10, k == 11);
      end
      if (done) dones++;
      if (spur && k == 3) begin valid = 1'b1; data_in = 5'h15; end
      if (restart && k == 4) start = 1'b1;
      if (restart && k == 5) start = 1'b0;
    end
    n_chk++;
    if (dones !== 1) begin n_fail++; $display("FAIL %s done_count: got %0d, expected 1", tag, dones); end
    n_chk++;
    if (snapshot !== exp_snap) begin n_fail++; $display("FAIL %s snapshot: got %h, expected %h", tag, snapshot, exp_snap); end
    n_chk++;
    if (total !== exp_total) begin n_fail++; $display("FAIL %s total: got %0d, expected %0d", tag, total, exp_total); end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    @(negedge clk);
    reset_L = 1'b1;
  endtask

  task automatic test_basic_scan();
    set_cnt(5'd3, 5'd0, 5'd7, 5'd31, 5'd12);
    run_scan(1'b0, 1'b0, 8'd53, "basic");
  endtask

  task automatic test_max_values();
    set_cnt(5'd31, 5'd31, 5'd31, 5'd31, 5'd31);
    run_scan(1'b0, 1'b0, 8'h9B, "max");
  endtask

  task automatic test_idle_gate();
    logic seen;
    idle = 1'b0;
    seen = 1'b0;
    start_pulse();
    repeat (20) begin @(negedge clk); if (req || busy) seen = 1'b1; end
    n_chk++;
    if (seen !== 1'b0) begin n_fail++; $display("FAIL idle_low: req/busy activity=%b, expected 0", seen); end
    idle = 1'b1;
    repeat (20) begin @(negedge clk); if (req || busy) seen = 1'b1; end
    n_chk++;
    if (seen !== 1'b0) begin n_fail++; $display("FAIL idle_no_memory: req/busy activity=%b, expected 0", seen); end
  endtask

  task automatic test_timeout();
    int dones, reqs, errc;
    dones = 0; reqs = 0; errc = -1;
    set_cnt(5'd1, 5'd2, 5'd3, 5'd4, 5'd5);
    start_pulse();
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (done) dones++;
      if (req) reqs++;
      if (error && errc < 0) errc = k;
      if (k == 6) begin resp_en = 1'b0; idle = 1'b0; end
    end
    n_chk++;
    if (errc < 1 || errc > 7 + TO + 2) begin n_fail++; $display("FAIL timeout_latency: error seen at cycle %0d, expected within 1..%0d", errc, 7 + TO + 2); end
    n_chk++;
    if ({error, err_idx, busy} !== {1'b1, 3'd3, 1'b0}) begin
      n_fail++;
      $display("FAIL timeout_flags: error=%b err_idx=%0d busy=%b, expected error=1 err_idx=3 busy=0", error, err_idx, busy);
    end
    n_chk++;
    if (dones !== 0 || reqs !== 4) begin n_fail++; $display("FAIL timeout_traffic: done pulses=%0d reqs=%0d, expected 0 and 4", dones, reqs); end
    n_chk++;
    if (snapshot !== {5'd31, 5'd31, 5'd3, 5'd2, 5'd1}) begin
      n_fail++;
      $display("FAIL timeout_snapshot: got %h, expected %h", snapshot, {5'd31, 5'd31, 5'd3, 5'd2, 5'd1});
    end
    n_chk++;
    if (total !== 8'd6) begin n_fail++; $display("FAIL timeout_total: got %0d, expected 6", total); end
    idle = 1'b1;
    resp_en = 1'b1;
    start_pulse();
    @(negedge clk);
    n_chk++;
    if ({error, err_idx, busy} !== {1'b0, 3'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL timeout_clear: error=%b err_idx=%0d busy=%b, expected error=0 err_idx=0 busy=1", error, err_idx, busy);
    end
    for (int k = 0; k < 15 && busy; k++) @(negedge clk);
    n_chk++;
    if (busy !== 1'b0 || total !== 8'd15) begin n_fail++; $display("FAIL timeout_rescan: busy=%b total=%0d, expected busy=0 total=15", busy, total); end
  endtask

  task automatic test_back_to_back();
    set_cnt(5'd3, 5'd0, 5'd7, 5'd31, 5'd12);
    run_scan(1'b1, 1'b1, 8'd53, "spurious_restart");
    run_scan(1'b0, 1'b0, 8'd53, "back_to_back");
  endtask

  task automatic test_async_reset();
    set_cnt(5'd9, 5'd9, 5'd9, 5'd9, 5'd9);
    start_pulse();
    repeat (4) @(negedge clk);
    #2;
    reset_L = 1'b0;
    #1;
    check_zero("async_reset");
    @(negedge clk);
    reset_L = 1'b1;
    set_cnt(5'd10, 5'd20, 5'd1, 5'd2, 5'd4);
    run_scan(1'b0, 1'b0, 8'd37, "post_reset");
  endtask

  initial begin
    test_reset();
    test_basic_scan();
    test_max_values();
    test_idle_gate();
    test_timeout();
    test_back_to_back();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
